// File: rtl/packet_sum_stage_if.sv
// Stream-in / result-out bundle for packet_sum_stage.
// The slave modport is the stage's view; the master modport drives beats and consumes results.
interface packet_sum_stage_if #(
    parameter int WIDTH     = 10,
    parameter int CNT_WIDTH = 8
);
    logic                 i_valid;
    logic                 o_ready;
    logic [WIDTH-1:0]     i_data;
    logic                 i_last;
    logic                 o_valid;
    logic                 i_ready;
    logic [WIDTH-1:0]     o_sum;
    logic [CNT_WIDTH-1:0] o_count;
    logic                 o_overflow;

    modport slave (
        input  i_valid, i_data, i_last, i_ready,
        output o_ready, o_valid, o_sum, o_count, o_overflow
    );

    modport master (
        output i_valid, i_data, i_last, i_ready,
        input  o_ready, o_valid, o_sum, o_count, o_overflow
    );
endinterface

// File: rtl/packet_sum_stage.sv
// Per-packet sum / beat count / overflow stage with a one-deep held result.
// Define PACKET_SUM_SATURATE_EN to clamp the sum at 2**WIDTH-1 instead of wrapping.
module packet_sum_stage #(
    parameter int WIDTH     = 10,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    packet_sum_stage_if.slave    bus
);
    typedef enum logic {ACC, HOLD} state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_acc;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_sticky;
    logic                 r_valid;
    logic [WIDTH-1:0]     r_sum;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_overflow;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_consume;
    logic [WIDTH:0]       w_sum_ext;
    logic                 w_carry;
    logic [WIDTH-1:0]     w_acc_next;
    logic [CNT_WIDTH-1:0] w_cnt_next;

    assign w_ready   = (r_state == ACC) || bus.i_ready;
    assign w_accept  = bus.i_valid && w_ready;
    assign w_consume = (r_state == HOLD) && bus.i_ready;

    assign w_sum_ext = {1'b0, r_acc} + {1'b0, bus.i_data};
    assign w_carry   = w_sum_ext[WIDTH];

`ifdef PACKET_SUM_SATURATE_EN
    // Once any carry has been seen the accumulator is pinned at full scale.
    assign w_acc_next = (r_sticky || w_carry) ? {WIDTH{1'b1}} : w_sum_ext[WIDTH-1:0];
`else
    assign w_acc_next = w_sum_ext[WIDTH-1:0];
`endif

    assign w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ACC;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_sticky   <= 1'b0;
            r_valid    <= 1'b0;
            r_sum      <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_consume) begin
                r_valid <= 1'b0;
                r_state <= ACC;
            end
            // A last beat on the consume cycle overrides the drop to ACC above.
            if (w_accept) begin
                if (bus.i_last) begin
                    r_sum      <= w_acc_next;
                    r_count    <= w_cnt_next;
                    r_overflow <= r_sticky | w_carry;
                    r_valid    <= 1'b1;
                    r_state    <= HOLD;
                    r_acc      <= '0;
                    r_cnt      <= '0;
                    r_sticky   <= 1'b0;
                end else begin
                    r_acc      <= w_acc_next;
                    r_cnt      <= w_cnt_next;
                    r_sticky   <= r_sticky | w_carry;
                end
            end
        end
    end

    assign bus.o_ready    = w_ready;
    assign bus.o_valid    = r_valid;
    assign bus.o_sum      = r_sum;
    assign bus.o_count    = r_count;
    assign bus.o_overflow = r_overflow;
endmodule

// File: tb/tb_packet_sum_stage.sv
// Randomized and directed bench for packet_sum_stage against a packet-level reference model.
// Expectations follow PACKET_SUM_SATURATE_EN when that macro is defined.
module tb_packet_sum_stage;
    localparam int WIDTH     = 10;
    localparam int CNT_WIDTH = 8;
    localparam int MAX_SUM   = (1 << WIDTH) - 1;
    localparam int MAX_CNT   = (1 << CNT_WIDTH) - 1;

    logic clk;
    logic rstN;

    packet_sum_stage_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) busIf ();

    packet_sum_stage #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .bus     (busIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int failCount  = 0;

    // Reference model: the beats of the open packet plus the result currently owed downstream.
    int  partialBeats[$];
    bit  expValid;
    int  expSum;
    int  expCount;
    bit  expOverflow;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic void clearModel();
        partialBeats.delete();
        expValid    = 1'b0;
        expSum      = 0;
        expCount    = 0;
        expOverflow = 1'b0;
    endfunction

    // Closes the open packet using plain arithmetic over all of its beats.
    function automatic void closePacket();
        int total = 0;
        foreach (partialBeats[k]) total += partialBeats[k];
        expOverflow = (total > MAX_SUM);
`ifdef PACKET_SUM_SATURATE_EN
        expSum = (total > MAX_SUM) ? MAX_SUM : total;
`else
        expSum = total % (MAX_SUM + 1);
`endif
        expCount = (partialBeats.size() > MAX_CNT) ? MAX_CNT : partialBeats.size();
        expValid = 1'b1;
        partialBeats.delete();
    endfunction

    // Drives one cycle of inputs, checks outputs mid-cycle, advances the model, ends at posedge+1.
    task automatic applyStimulus(input bit valid, input int data, input bit last, input bit ready);
        bit expReady;
        busIf.i_valid = valid;
        busIf.i_data  = data[WIDTH-1:0];
        busIf.i_last  = last;
        busIf.i_ready = ready;
        @(negedge clk);
        expReady = !expValid || ready;
        checkOutput("o_ready", int'(busIf.o_ready), int'(expReady));
        checkOutput("o_valid", int'(busIf.o_valid), int'(expValid));
        if (expValid) begin
            checkOutput("o_sum",      int'(busIf.o_sum),      expSum);
            checkOutput("o_count",    int'(busIf.o_count),    expCount);
            checkOutput("o_overflow", int'(busIf.o_overflow), int'(expOverflow));
        end
        if (valid && expReady) begin
            partialBeats.push_back(data % (MAX_SUM + 1));
            if (last) closePacket();
            else if (expValid && ready) expValid = 1'b0;
        end else if (expValid && ready) begin
            expValid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset(input int cycles);
        rstN = 1'b0;
        clearModel();
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            checkOutput("rst_o_valid",    int'(busIf.o_valid),    0);
            checkOutput("rst_o_ready",    int'(busIf.o_ready),    1);
            checkOutput("rst_o_sum",      int'(busIf.o_sum),      0);
            checkOutput("rst_o_count",    int'(busIf.o_count),    0);
            checkOutput("rst_o_overflow", int'(busIf.o_overflow), 0);
            @(posedge clk);
            #1;
        end
        rstN = 1'b1;
    endtask

    initial begin
        int data;
        busIf.i_valid = 1'b0;
        busIf.i_data  = '0;
        busIf.i_last  = 1'b0;
        busIf.i_ready = 1'b0;
        rstN          = 1'b0;
        clearModel();
        @(posedge clk);
        #1;

        applyReset(3);

        // Three-beat packet with results visible one cycle after the last beat.
        applyStimulus(1, 3, 0, 1);
        applyStimulus(1, 4, 0, 1);
        applyStimulus(1, 5, 1, 1);
        checkOutput("t2_valid", int'(busIf.o_valid), 1);
        checkOutput("t2_sum",   int'(busIf.o_sum),   12);
        checkOutput("t2_count", int'(busIf.o_count), 3);
        checkOutput("t2_ovf",   int'(busIf.o_overflow), 0);

        // Stall downstream with a beat waiting, then release so it lands on the consume cycle.
        for (int c = 0; c < 5; c++) applyStimulus(1, 8, 1, 0);
        checkOutput("t3_held_sum", int'(busIf.o_sum), 12);
        applyStimulus(1, 8, 1, 1);
        checkOutput("t3_new_sum", int'(busIf.o_sum), 8);
        applyStimulus(0, 0, 0, 1);

        // Overflow packet: wraps to 76 or clamps to full scale.
        applyStimulus(1, 1000, 0, 1);
        applyStimulus(1, 100, 1, 1);
`ifdef PACKET_SUM_SATURATE_EN
        checkOutput("t4_sum", int'(busIf.o_sum), 1023);
`else
        checkOutput("t4_sum", int'(busIf.o_sum), 76);
`endif
        checkOutput("t4_ovf", int'(busIf.o_overflow), 1);

        // Back-to-back single-beat packets keep o_valid high.
        applyStimulus(1, 7, 1, 1);
        checkOutput("t5_sum7",   int'(busIf.o_sum),   7);
        checkOutput("t5_valid7", int'(busIf.o_valid), 1);
        applyStimulus(1, 9, 1, 1);
        checkOutput("t5_sum9",   int'(busIf.o_sum),   9);
        checkOutput("t5_valid9", int'(busIf.o_valid), 1);
        checkOutput("t5_cnt9",   int'(busIf.o_count), 1);
        applyStimulus(0, 0, 0, 1);

        // Mid-packet reset must discard the partial sum.
        applyStimulus(1, 5, 0, 1);
        applyStimulus(1, 6, 0, 1);
        busIf.i_valid = 1'b0;
        applyReset(2);
        applyStimulus(1, 2, 1, 1);
        checkOutput("t6_sum",   int'(busIf.o_sum),   2);
        checkOutput("t6_count", int'(busIf.o_count), 1);
        applyStimulus(0, 0, 0, 1);

        // Long packet drives the beat counter into saturation.
        for (int b = 0; b < 259; b++) applyStimulus(1, b % 4, 0, 1);
        applyStimulus(1, 1, 1, 1);
        checkOutput("cnt_sat", int'(busIf.o_count), MAX_CNT);
        applyStimulus(0, 0, 0, 1);

        // Random traffic with bubbles, stalls and occasional large data.
        for (int c = 0; c < 600; c++) begin
            data = ($urandom_range(0, 3) == 0) ? int'($urandom_range(512, MAX_SUM))
                                               : int'($urandom_range(0, 120));
            applyStimulus($urandom_range(0, 9) < 7, data,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 6);
        end

        // Reset while a result is pending drops it.
        applyStimulus(1, 11, 1, 0);
        applyReset(1);
        applyStimulus(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule
